// File: rtl/ram_pkg.sv
// ----------------------------------------------------------------------------
// ram_pkg
// Shared definitions for the RAM bus initiator:
//   - default bus geometry (1K x 8: 2 bank-select bits + 8 row bits)
//   - FSM state encodings, kept as plain localparam constants so that the
//     encoding is fixed and visible in waveforms of older tools
//   - RWS pin polarity constants
//   - small constant helper used to size the phase wait counter
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

package ram_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 8;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_SETUP = 3'd1;
    localparam state_t ST_WRITE = 3'd2;
    localparam state_t ST_VREL  = 3'd3;
    localparam state_t ST_READ  = 3'd4;
    localparam state_t ST_TURN  = 3'd5;

    localparam logic RWS_READ  = 1'b0;
    localparam logic RWS_WRITE = 1'b1;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ram_bus_master_drv.sv
// ----------------------------------------------------------------------------
// ram_bus_drv
// Tristate driver for the shared RAM data bus. This is the only place in the
// initiator that can put a value on the bus; everything else sees the bus
// through the din tap.
// Ports:
//   oe    in     1       drive enable (high only during the write phase)
//   dout  in     DATA_W  value driven while oe is high
//   din   out    DATA_W  current value seen on the bus
//   data  inout  DATA_W  shared RAM data bus
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module ram_bus_drv #(
    parameter int DATA_W = 8
) (
    input  logic              oe,
    input  logic [DATA_W-1:0] dout,
    output logic [DATA_W-1:0] din,
    inout  wire  [DATA_W-1:0] data
);

    assign data = oe ? dout : {DATA_W{1'bz}};
    assign din  = data;

endmodule

// File: rtl/ram_bus_master.sv
// ----------------------------------------------------------------------------
// ram_bus_master
// Initiator for the shared 1K x 8 RAM bus. Accepts one read or write at a time
// on a valid/ready handshake and sequences SETUP -> WRITE|READ -> TURN -> IDLE
// on the RAM address/control pins. The data bus is driven only in WRITE.
//
// Optional feature (macro RAM_WRITE_VERIFY_EN): every write is followed by a
// release cycle (VREL) and a read-back at the same address; rsp_err flags a
// mismatch between the read-back and the written data.
//
// Ports:
//   clk        in     1       system clock, rising edge
//   rst_n      in     1       synchronous active-low reset
//   req_valid  in     1       client request valid
//   req_ready  out    1       master idle, request accepted at next edge
//   req_write  in     1       1 = write, 0 = read
//   req_addr   in     ADDR_W  word address
//   req_wdata  in     DATA_W  write data
//   rsp_valid  out    1       one-cycle completion pulse (TURN state)
//   rsp_rdata  out    DATA_W  last captured read data
//   rsp_err    out    1       write-verify mismatch (0 when feature disabled)
//   ram_data   inout  DATA_W  shared RAM data bus
//   ram_addr   out    ADDR_W  RAM address
//   ram_en     out    1       RAM decoder enable
//   ram_rws    out    1       1 = write, 0 = read
//   ram_cs     out    1       RAM chip select
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module ram_bus_master
    import ram_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int WR_HOLD = 2,
    parameter int RD_WAIT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    inout  wire  [DATA_W-1:0] ram_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_en,
    output logic              ram_rws,
    output logic              ram_cs
);

    localparam int CNT_W = $clog2(max2(WR_HOLD, RD_WAIT)) + 1;
    // Counter counts down to zero, so a phase of N cycles loads N-1.
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_HOLD - 1);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);

    state_t            state;
    logic [CNT_W-1:0]  wait_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              write_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] bus_in;
    logic              bus_oe;
`ifdef RAM_WRITE_VERIFY_EN
    logic              err_q;
`endif

    // Main sequencer. Request fields are latched only on the handshake edge,
    // so the client may change its inputs freely once the request is taken.
    // The read capture happens on the edge that ends the last READ cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= RWS_READ;
            rdata_q  <= '0;
`ifdef RAM_WRITE_VERIFY_EN
            err_q    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        write_q <= req_write;
`ifdef RAM_WRITE_VERIFY_EN
                        err_q   <= 1'b0;
`endif
                        state   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (write_q) begin
                        state    <= ST_WRITE;
                        wait_cnt <= WR_LOAD;
                    end else begin
                        state    <= ST_READ;
                        wait_cnt <= RD_LOAD;
                    end
                end
                ST_WRITE: begin
                    if (wait_cnt == '0) begin
`ifdef RAM_WRITE_VERIFY_EN
                        state <= ST_VREL;
`else
                        state <= ST_TURN;
`endif
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ST_VREL: begin
                    state    <= ST_READ;
                    wait_cnt <= RD_LOAD;
                end
                ST_READ: begin
                    if (wait_cnt == '0) begin
                        rdata_q <= bus_in;
`ifdef RAM_WRITE_VERIFY_EN
                        err_q   <= write_q && (bus_in != wdata_q);
`endif
                        state   <= ST_TURN;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ST_TURN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // RWS follows the request through SETUP/WRITE/TURN. A verified write
    // switches to read for the release and read-back, and stays read in TURN.
    always_comb begin
        ram_rws = RWS_READ;
        case (state)
            ST_SETUP, ST_WRITE: ram_rws = write_q;
`ifdef RAM_WRITE_VERIFY_EN
            ST_TURN:            ram_rws = RWS_READ;
`else
            ST_TURN:            ram_rws = write_q;
`endif
            default:            ram_rws = RWS_READ;
        endcase
    end

    assign req_ready = (state == ST_IDLE);
    assign ram_cs    = (state == ST_WRITE) || (state == ST_READ);
    assign ram_en    = (state != ST_IDLE);
    assign ram_addr  = addr_q;
    assign bus_oe    = (state == ST_WRITE);
    assign rsp_valid = (state == ST_TURN);
    assign rsp_rdata = rdata_q;
`ifdef RAM_WRITE_VERIFY_EN
    assign rsp_err   = err_q;
`else
    assign rsp_err   = 1'b0;
`endif

    ram_bus_drv #(
        .DATA_W (DATA_W)
    ) u_drv (
        .oe   (bus_oe),
        .dout (wdata_q),
        .din  (bus_in),
        .data (ram_data)
    );

endmodule

// File: tb/tb_ram_bus_master.sv
// ----------------------------------------------------------------------------
// tb_ram_bus_master
// Directed bench for ram_bus_master with a behavioural 1K x 8 RAM on the
// shared bus. The bus carries pull-ups so an undriven bus reads as 0xFF.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_ram_bus_master;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [9:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    wire  [7:0] ram_data;
    logic [9:0] ram_addr;
    logic       ram_en;
    logic       ram_rws;
    logic       ram_cs;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural RAM
    logic [7:0] mem [0:1023];
    logic       stuck_bit0 = 1'b0;
    logic       pre_we = 1'b0;
    logic [9:0] pre_addr = '0;
    logic [7:0] pre_data = '0;
    logic       ram_drv;
    logic [7:0] ram_q;
    logic       mon_en = 1'b0;
    int         bus_err = 0;

    // Results of the most recent transaction
    int         lat;
    int         cs_cnt;
    int         cs_wr_cnt;
    int         ready_seen;
    logic [7:0] cs_bus;
    logic       saw_valid;

    always #5 clk = ~clk;

    ram_bus_master dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .ram_data  (ram_data),
        .ram_addr  (ram_addr),
        .ram_en    (ram_en),
        .ram_rws   (ram_rws),
        .ram_cs    (ram_cs)
    );

    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (ram_data[g]);
    end

    assign ram_drv  = ram_cs && (ram_rws == 1'b0);
    assign ram_q    = stuck_bit0 ? (mem[ram_addr] & 8'hFE) : mem[ram_addr];
    assign ram_data = ram_drv ? ram_q : 8'hzz;

    always @(posedge clk) begin
        if (pre_we)
            mem[pre_addr] <= pre_data;
        else if (ram_cs && ram_rws)
            mem[ram_addr] <= ram_data;
    end

    // Bus ownership monitor: when the RAM drives, the bus must carry exactly
    // the RAM value (no contention); outside WRITE and RAM read it must float.
    always @(negedge clk) begin
        if (mon_en) begin
            if (ram_drv) begin
                if (ram_data !== ram_q) bus_err++;
            end else if (!(ram_cs && ram_rws)) begin
                if (ram_data !== 8'hFF) bus_err++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [9:0] a, input logic [7:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(posedge clk);
        #1;
        pre_we   = 1'b0;
    endtask

    // Presents a request and returns #1 after the acceptance edge.
    task automatic issue(input logic w, input logic [9:0] a, input logic [7:0] d, input logic drop);
        int k;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        k = 0;
        while (!req_ready && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("accept_wait", (k < 20), 1'b1);
        @(posedge clk);
        #1;
        if (drop) req_valid = 1'b0;
    endtask

    // Follows the transaction edge by edge until rsp_valid (bounded).
    // lat counts the acceptance edge as edge 1.
    task automatic run_to_rsp();
        lat        = 1;
        cs_cnt     = 0;
        cs_wr_cnt  = 0;
        ready_seen = 0;
        cs_bus     = 8'h00;
        saw_valid  = 1'b0;
        while (!saw_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (ram_cs) begin
                cs_cnt++;
                if (ram_rws) cs_wr_cnt++;
                cs_bus = ram_data;
            end
            if (req_ready) ready_seen++;
            if (rsp_valid) saw_valid = 1'b1;
        end
    endtask

    initial begin
        int quiet;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;

        // Reset held for several cycles, RAM contents preloaded meanwhile
        repeat (3) @(posedge clk);
        #1;
        preload(10'h001, 8'h3C);
        preload(10'h010, 8'h77);
        check("rst_cs",    ram_cs,    1'b0);
        check("rst_en",    ram_en,    1'b0);
        check("rst_rws",   ram_rws,   1'b0);
        check("rst_addr",  ram_addr,  10'h000);
        check("rst_bus",   ram_data,  8'hFF);
        check("rst_valid", rsp_valid, 1'b0);
        check("rst_rdata", rsp_rdata, 8'h00);
        check("rst_err",   rsp_err,   1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_ready", req_ready, 1'b1);
        mon_en = 1'b1;

        // Write 0x2A5 <- 0x5C
        issue(1'b1, 10'h2A5, 8'h5C, 1'b1);
        run_to_rsp();
        check("wr_latency",  lat,         4);
        check("wr_cs_cyc",   cs_cnt,      2);
        check("wr_rws_cyc",  cs_wr_cnt,   2);
        check("wr_bus",      cs_bus,      8'h5C);
        check("wr_err",      rsp_err,     1'b0);
        check("wr_mem",      mem[10'h2A5], 8'h5C);
        check("wr_rdata_kept", rsp_rdata, 8'h00);
        @(posedge clk);
        #1;
        check("wr_end_en",   ram_en,      1'b0);

        // Read 0x2A5 back
        issue(1'b0, 10'h2A5, 8'h00, 1'b1);
        run_to_rsp();
        check("rd_latency",  lat,       4);
        check("rd_cs_cyc",   cs_cnt,    2);
        check("rd_rws_cyc",  cs_wr_cnt, 0);
        check("rd_rdata",    rsp_rdata, 8'h5C);
        check("rd_err",      rsp_err,   1'b0);
        @(posedge clk);
        #1;

        // Back-to-back: read 0x001 then write 0x3FF <- 0xFF, req_valid held
        issue(1'b0, 10'h001, 8'h00, 1'b0);
        req_write = 1'b1;
        req_addr  = 10'h3FF;
        req_wdata = 8'hFF;
        run_to_rsp();
        check("b2b_rd_latency", lat,        4);
        check("b2b_ready_busy", ready_seen, 0);
        check("b2b_rd_rdata",   rsp_rdata,  8'h3C);
        @(posedge clk);
        #1;
        check("b2b_idle_ready", req_ready,  1'b1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("b2b_accepted",   ram_en,     1'b1);
        run_to_rsp();
        check("b2b_wr_latency", lat,         4);
        check("b2b_wr_bus",     cs_bus,      8'hFF);
        check("b2b_wr_mem",     mem[10'h3FF], 8'hFF);
        check("b2b_rdata_kept", rsp_rdata,   8'h3C);
        check("b2b_bus_own",    bus_err,     0);
        @(posedge clk);
        #1;

        // Reset during the first WRITE cycle
        issue(1'b1, 10'h100, 8'hAA, 1'b1);
        @(posedge clk);
        #1;
        check("abort_in_write", ram_cs, 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_cs",    ram_cs,    1'b0);
        check("abort_en",    ram_en,    1'b0);
        check("abort_bus",   ram_data,  8'hFF);
        check("abort_valid", rsp_valid, 1'b0);
        check("abort_addr",  ram_addr,  10'h000);
        rst_n = 1'b1;
        quiet = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (rsp_valid) quiet++;
        end
        check("abort_no_rsp", quiet, 0);

        issue(1'b0, 10'h010, 8'h00, 1'b1);
        run_to_rsp();
        check("post_rd_latency", lat,       4);
        check("post_rd_rdata",   rsp_rdata, 8'h77);
        @(posedge clk);
        #1;

`ifdef RAM_WRITE_VERIFY_EN
        // Verified write against a RAM with bit 0 stuck low
        stuck_bit0 = 1'b1;
        issue(1'b1, 10'h00F, 8'h81, 1'b1);
        run_to_rsp();
        check("vfy_latency", lat,       7);
        check("vfy_cs_cyc",  cs_cnt,    4);
        check("vfy_rws_cyc", cs_wr_cnt, 2);
        check("vfy_rdata",   rsp_rdata, 8'h80);
        check("vfy_err",     rsp_err,   1'b1);
        stuck_bit0 = 1'b0;
        @(posedge clk);
        #1;
        issue(1'b0, 10'h010, 8'h00, 1'b1);
        run_to_rsp();
        check("vfy_rd_err",  rsp_err,   1'b0);
        check("vfy_rd_rdata", rsp_rdata, 8'h77);
`else
        issue(1'b1, 10'h00F, 8'h81, 1'b1);
        run_to_rsp();
        check("nv_latency",    lat,       4);
        check("nv_err",        rsp_err,   1'b0);
        check("nv_rdata_kept", rsp_rdata, 8'h77);
`endif
        @(posedge clk);
        #1;
        check("final_bus_own", bus_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
